bus_rr_xbar: RTL and testbench
==============================

# bus_rr_xbar

Parametrised successor to the system bus interconnect. It connects `NrHosts` request/grant hosts (core data port, debug SBA, future DMA) to `NrDevices` single-cycle-response devices over one shared layer. It adds selectable round-robin arbitration and an internal decode-error responder for unmapped addresses. It sits between the hosts and the device array in `ibex_demo_system`, using the same `cfg_device_addr_base`/`cfg_device_addr_mask` decode.

## Interface
- `NrHosts`, 3, number of hosts; 1..8
- `NrDevices`, 8, number of devices; 1..16
- `DataWidth`, 32, data width in bits
- `AddressWidth`, 32, address width in bits
- `RoundRobin`, 1, 1 = rotating priority; 0 = fixed priority, lowest host index wins
- `clk_i`  in  1  system clock; the only clock
- `rst_ni`  in  1  asynchronous active-low reset
- `host_req_i/host_we_i`  in  1 [NrHosts]  host request / write enable
- `host_addr_i`  in  AddressWidth [NrHosts]  byte address
- `host_be_i`  in  DataWidth/8 [NrHosts]  byte enables
- `host_wdata_i`  in  DataWidth [NrHosts]  write data
- `host_gnt_o`  out  1 [NrHosts]  request accepted this cycle
- `host_rvalid_o/host_err_o`  out  1 [NrHosts]  response valid / error
- `host_rdata_o`  out  DataWidth [NrHosts]  read data
- `device_req_o/device_we_o`  out  1 [NrDevices]  device request / write enable
- `device_addr_o`  out  AddressWidth [NrDevices]  address
- `device_be_o`  out  DataWidth/8 [NrDevices]  byte enables
- `device_wdata_o`  out  DataWidth [NrDevices]  write data
- `device_rvalid_i/device_err_i`  in  1 [NrDevices]  response valid / error
- `device_rdata_i`  in  DataWidth [NrDevices]  read data
- `cfg_device_addr_base/mask`  in  AddressWidth [NrDevices]  decode window

## Operation
- Arbitration happens every cycle among asserted `host_req_i`. Exactly one host is granted per cycle, or none.
- Fixed mode: the lowest requesting index wins.
- Round-robin mode: search starts at `rr_ptr`, wrapping modulo `NrHosts`. On every grant, `rr_ptr` <= granted index + 1 (wraps to 0). `rr_ptr` holds when there is no grant.
- Decode: device d matches when `(addr & mask[d]) == base[d]`. With multiple matches, the lowest index wins.
- Granted host with a device match:
  - `device_req_o[d]` = 1 in the same cycle; addr/we/be/wdata are passed through combinationally.
  - `host_gnt_o[h]` = 1 in the same cycle.
- Granted host with no match (unmapped): `host_gnt_o[h]` = 1 and no device request is issued. The internal error responder answers.
- Response tracking registers `{valid, host_idx, dev_idx, unmapped}` at grant.
- Next cycle, `host_rvalid_o[host_idx]` follows the response:
  - Mapped: `device_rvalid_i[dev_idx]`, with rdata/err from the device.
  - Unmapped: rvalid = 1, err = 1, rdata = 0.
- Device responses arriving with no tracked transaction, or for a different device index, are dropped.
- Non-granted device outputs: req = 0, we = 0, addr/be/wdata = 0.
- Non-addressed host outputs: gnt/rvalid/err = 0, rdata = 0.

## Timing
- Grant and device request are combinational from host request, with zero-cycle latency.
- Response arrives exactly 1 cycle after grant. Devices must respond in the cycle after `device_req_o`.
- Back-to-back grants every cycle are supported. The response for cycle N overlaps the grant for cycle N+1.
- A host may keep `req` high after gnt and is re-arbitrated normally.
- Reset (asynchronous assert, synchronous deassert by system) sets:
  - `rr_ptr` = 0
  - tracking valid = 0
  - all `host_rvalid_o` = 0 and `host_err_o` = 0
- Reset mid-transaction: the pending response is discarded. No rvalid is produced after reset release for pre-reset grants.
- `NrHosts` = 1: arbitration degenerates to pass-through and `rr_ptr` stays 0.

## Test plan
- Single host: write 0xDEADBEEF to 0x00100010 then read it back. Expect gnt in the request cycle, RAM req with be=0xF, and read rvalid 1 cycle later with data 0xDEADBEEF and err=0.
- Three hosts hold req continuously, `RoundRobin`=1. Expect grants in order 0,1,2,0,1,2 and each host's rvalid one cycle after its grant.
- Same stimulus with `RoundRobin`=0. Expect host 0 granted every cycle, hosts 1 and 2 never granted.
- Host 1 reads 0x40000000 (unmapped). Expect gnt, no device req, and next cycle rvalid=1, err=1, rdata=0 on host 1 only.
- Timer window returns `device_err_i`=1. Expect `host_err_o`=1 forwarded with rvalid to the owning host.
- Grant issued, then `rst_ni` pulsed low before the response cycle. Expect no rvalid after release and the next grant to go to host 0.

Source files
------------

// File: rtl/bus_rr_xbar_if.sv
// rtl/bus_rr_xbar_if.sv - host and device signal bundle for the round-robin bus crossbar
interface bus_rr_xbar_if #(
  parameter int NrHosts      = 3,
  parameter int NrDevices    = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [NrHosts-1:0]                      host_req_i;
  logic [NrHosts-1:0]                      host_we_i;
  logic [NrHosts-1:0][AddressWidth-1:0]    host_addr_i;
  logic [NrHosts-1:0][DataWidth/8-1:0]     host_be_i;
  logic [NrHosts-1:0][DataWidth-1:0]       host_wdata_i;
  logic [NrHosts-1:0]                      host_gnt_o;
  logic [NrHosts-1:0]                      host_rvalid_o;
  logic [NrHosts-1:0]                      host_err_o;
  logic [NrHosts-1:0][DataWidth-1:0]       host_rdata_o;

  logic [NrDevices-1:0]                    device_req_o;
  logic [NrDevices-1:0]                    device_we_o;
  logic [NrDevices-1:0][AddressWidth-1:0]  device_addr_o;
  logic [NrDevices-1:0][DataWidth/8-1:0]   device_be_o;
  logic [NrDevices-1:0][DataWidth-1:0]     device_wdata_o;
  logic [NrDevices-1:0]                    device_rvalid_i;
  logic [NrDevices-1:0]                    device_err_i;
  logic [NrDevices-1:0][DataWidth-1:0]     device_rdata_i;

  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_base;
  logic [NrDevices-1:0][AddressWidth-1:0]  cfg_device_addr_mask;

  modport slave (
    input  host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    output host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    output device_req_o, device_we_o, device_addr_o, device_be_o, device_wdata_o,
    input  device_rvalid_i, device_err_i, device_rdata_i,
    input  cfg_device_addr_base, cfg_device_addr_mask
  );

  modport master (
    output host_req_i, host_we_i, host_addr_i, host_be_i, host_wdata_i,
    input  host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o,
    input  device_req_o, device_we_o, device_addr_o, device_be_o, device_wdata_o,
    output device_rvalid_i, device_err_i, device_rdata_i,
    output cfg_device_addr_base, cfg_device_addr_mask
  );
endinterface

// File: rtl/bus_rr_xbar.sv
// rtl/bus_rr_xbar.sv - single-layer host/device crossbar with round-robin or fixed arbitration
// Unmapped accesses are granted and answered next cycle by an internal error responder.
module bus_rr_xbar #(
  parameter int NrHosts      = 3,
  parameter int NrDevices    = 8,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32,
  parameter bit RoundRobin   = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bus_rr_xbar_if.slave  bus
);
  localparam int HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  logic [HostIdxW-1:0]     rr_ptr;
  logic [HostIdxW-1:0]     gnt_idx;
  logic                    gnt_valid;
  logic [AddressWidth-1:0] sel_addr;
  logic [DevIdxW-1:0]      dev_idx;
  logic                    dev_hit;

  logic                    trk_valid;
  logic [HostIdxW-1:0]     trk_host;
  logic [DevIdxW-1:0]      trk_dev;
  logic                    trk_unmapped;

  // Search starts at rr_ptr in rotating mode, at index 0 in fixed mode.
  always_comb begin
    int cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NrHosts; k++) begin
      cand = RoundRobin ? int'(rr_ptr) + k : k;
      if (cand >= NrHosts) cand = cand - NrHosts;
      if (!gnt_valid && bus.host_req_i[HostIdxW'(cand)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = HostIdxW'(cand);
      end
    end
  end

  always_comb begin
    sel_addr = bus.host_addr_i[gnt_idx];
    dev_hit  = 1'b0;
    dev_idx  = '0;
    for (int d = 0; d < NrDevices; d++) begin
      if (!dev_hit && ((sel_addr & bus.cfg_device_addr_mask[DevIdxW'(d)])
                       == bus.cfg_device_addr_base[DevIdxW'(d)])) begin
        dev_hit = 1'b1;
        dev_idx = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    bus.host_gnt_o     = '0;
    bus.device_req_o   = '0;
    bus.device_we_o    = '0;
    bus.device_addr_o  = '0;
    bus.device_be_o    = '0;
    bus.device_wdata_o = '0;
    if (gnt_valid) begin
      bus.host_gnt_o[gnt_idx] = 1'b1;
      if (dev_hit) begin
        bus.device_req_o[dev_idx]   = 1'b1;
        bus.device_we_o[dev_idx]    = bus.host_we_i[gnt_idx];
        bus.device_addr_o[dev_idx]  = sel_addr;
        bus.device_be_o[dev_idx]    = bus.host_be_i[gnt_idx];
        bus.device_wdata_o[dev_idx] = bus.host_wdata_i[gnt_idx];
      end
    end
  end

  // Device responses not matching the tracked device are never routed anywhere.
  always_comb begin
    bus.host_rvalid_o = '0;
    bus.host_err_o    = '0;
    bus.host_rdata_o  = '0;
    if (trk_valid) begin
      if (trk_unmapped) begin
        bus.host_rvalid_o[trk_host] = 1'b1;
        bus.host_err_o[trk_host]    = 1'b1;
      end else begin
        bus.host_rvalid_o[trk_host] = bus.device_rvalid_i[trk_dev];
        bus.host_err_o[trk_host]    = bus.device_err_i[trk_dev];
        bus.host_rdata_o[trk_host]  = bus.device_rdata_i[trk_dev];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr       <= '0;
      trk_valid    <= 1'b0;
      trk_host     <= '0;
      trk_dev      <= '0;
      trk_unmapped <= 1'b0;
    end else begin
      trk_valid <= gnt_valid;
      if (gnt_valid) begin
        trk_host     <= gnt_idx;
        trk_dev      <= dev_idx;
        trk_unmapped <= !dev_hit;
        rr_ptr       <= (int'(gnt_idx) == NrHosts - 1) ? '0 : gnt_idx + HostIdxW'(1);
      end
    end
  end
endmodule

// File: tb/tb_bus_rr_xbar.sv
// tb/tb_bus_rr_xbar.sv - scoreboard bench for bus_rr_xbar, rotating and fixed instances side by side
module tb_bus_rr_xbar;
  localparam int NH = 3;
  localparam int ND = 8;

  typedef struct {
    int          cyc;
    int          host;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst_next;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NH-1:0]           h_req, h_we, n_req, n_we;
  logic [NH-1:0][31:0]     h_addr, h_wdata, n_addr, n_wdata;
  logic [NH-1:0][3:0]      h_be, n_be;
  logic [ND-1:0][31:0]     cfg_base, cfg_mask;

  logic [ND-1:0]           dev_rvalid [2];
  logic [ND-1:0]           dev_err    [2];
  logic [ND-1:0][31:0]     dev_rdata  [2];
  logic [ND-1:0]           pend_v     [2];
  logic [ND-1:0]           pend_e     [2];
  logic [ND-1:0][31:0]     pend_d     [2];

  logic [NH-1:0]           gnt_s    [2];
  logic [NH-1:0]           rvalid_s [2];
  logic [NH-1:0]           err_s    [2];
  logic [NH-1:0][31:0]     rdata_s  [2];
  logic [ND-1:0]           dreq_s   [2];
  logic [ND-1:0]           dwe_s    [2];
  logic [ND-1:0][31:0]     daddr_s  [2];
  logic [ND-1:0][3:0]      dbe_s    [2];
  logic [ND-1:0][31:0]     dwdata_s [2];

  bus_rr_xbar_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32)) bus_rr ();
  bus_rr_xbar_if #(.NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32)) bus_fx ();

  bus_rr_xbar #(.NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32), .RoundRobin(1'b1))
    dut_rr (.clk_i(clk), .rst_ni(rst_n), .bus(bus_rr));
  bus_rr_xbar #(.NrHosts(NH), .NrDevices(ND), .DataWidth(32), .AddressWidth(32), .RoundRobin(1'b0))
    dut_fx (.clk_i(clk), .rst_ni(rst_n), .bus(bus_fx));

  assign bus_rr.host_req_i = h_req;   assign bus_fx.host_req_i = h_req;
  assign bus_rr.host_we_i = h_we;     assign bus_fx.host_we_i = h_we;
  assign bus_rr.host_addr_i = h_addr; assign bus_fx.host_addr_i = h_addr;
  assign bus_rr.host_be_i = h_be;     assign bus_fx.host_be_i = h_be;
  assign bus_rr.host_wdata_i = h_wdata; assign bus_fx.host_wdata_i = h_wdata;
  assign bus_rr.cfg_device_addr_base = cfg_base; assign bus_fx.cfg_device_addr_base = cfg_base;
  assign bus_rr.cfg_device_addr_mask = cfg_mask; assign bus_fx.cfg_device_addr_mask = cfg_mask;
  assign bus_rr.device_rvalid_i = dev_rvalid[0]; assign bus_fx.device_rvalid_i = dev_rvalid[1];
  assign bus_rr.device_err_i = dev_err[0];       assign bus_fx.device_err_i = dev_err[1];
  assign bus_rr.device_rdata_i = dev_rdata[0];   assign bus_fx.device_rdata_i = dev_rdata[1];

  assign gnt_s[0] = bus_rr.host_gnt_o;       assign gnt_s[1] = bus_fx.host_gnt_o;
  assign rvalid_s[0] = bus_rr.host_rvalid_o; assign rvalid_s[1] = bus_fx.host_rvalid_o;
  assign err_s[0] = bus_rr.host_err_o;       assign err_s[1] = bus_fx.host_err_o;
  assign rdata_s[0] = bus_rr.host_rdata_o;   assign rdata_s[1] = bus_fx.host_rdata_o;
  assign dreq_s[0] = bus_rr.device_req_o;    assign dreq_s[1] = bus_fx.device_req_o;
  assign dwe_s[0] = bus_rr.device_we_o;      assign dwe_s[1] = bus_fx.device_we_o;
  assign daddr_s[0] = bus_rr.device_addr_o;  assign daddr_s[1] = bus_fx.device_addr_o;
  assign dbe_s[0] = bus_rr.device_be_o;      assign dbe_s[1] = bus_fx.device_be_o;
  assign dwdata_s[0] = bus_rr.device_wdata_o; assign dwdata_s[1] = bus_fx.device_wdata_o;

  int checks = 0;
  int errors = 0;
  exp_t sbq [2][$];
  int rr_m [2];
  logic [31:0] mem_m [longint];
  logic [31:0] ram   [longint];
  int rr_log[$];
  int fx_other;

  task automatic chk(string name, int g, logic [511:0] got, logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h", name, g, got, want);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // Reference: instance 0 rotates from its pointer, instance 1 always scans from host 0.
  function automatic int pick(int g);
    for (int k = 0; k < NH; k++) begin
      int i = (g == 0) ? (rr_m[g] + k) % NH : k;
      if (h_req[i]) return i;
    end
    return -1;
  endfunction

  function automatic int decode(logic [31:0] a);
    for (int d = 0; d < ND; d++) if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  task automatic check_inst(int g);
    int h, d, act;
    logic [NH-1:0] e_gnt = '0;
    logic [ND-1:0] e_req = '0, e_we = '0;
    logic [ND-1:0][31:0] e_addr = '0, e_wdata = '0;
    logic [ND-1:0][3:0] e_be = '0;
    exp_t e;
    longint key;
    h = pick(g);
    d = -1;
    if (h >= 0) begin
      e_gnt[h] = 1'b1;
      d = decode(h_addr[h]);
      if (d >= 0) begin
        e_req[d] = 1'b1; e_we[d] = h_we[h]; e_addr[d] = h_addr[h];
        e_be[d] = h_be[h]; e_wdata[d] = h_wdata[h];
      end
    end
    chk("gnt", g, 512'(gnt_s[g]), 512'(e_gnt));
    chk("dev_ctl", g, 512'({dreq_s[g], dwe_s[g], dbe_s[g]}), 512'({e_req, e_we, e_be}));
    chk("dev_addr", g, 512'(daddr_s[g]), 512'(e_addr));
    chk("dev_wdata", g, 512'(dwdata_s[g]), 512'(e_wdata));
    act = -1;
    for (int i = 0; i < NH; i++) if (gnt_s[g][i] && act < 0) act = i;
    if (g == 0) rr_log.push_back(act);
    else if (act > 0) fx_other++;
    // Device array: RAM-like storage, device 2 is the timer that flags errors.
    for (int dd = 0; dd < ND; dd++) begin
      if (dreq_s[g][dd]) begin
        key = (longint'(g) << 32) | longint'(daddr_s[g][dd] >> 2);
        pend_v[g][dd] = 1'b1;
        pend_e[g][dd] = (dd == 2);
        if (dwe_s[g][dd]) begin
          ram[key] = merge(ram.exists(key) ? ram[key] : 32'h0, dwdata_s[g][dd], dbe_s[g][dd]);
          pend_d[g][dd] = 32'h0;
        end else begin
          pend_d[g][dd] = ram.exists(key) ? ram[key] : 32'h0;
        end
      end
    end
    if (h >= 0) begin
      rr_m[g] = (h + 1) % NH;
      e.cyc = cyc; e.host = h; e.rdata = 32'h0; e.err = 1'b1;
      if (d >= 0) begin
        key = (longint'(g) << 32) | longint'(h_addr[h] >> 2);
        e.err = (d == 2);
        if (h_we[h]) mem_m[key] = merge(mem_m.exists(key) ? mem_m[key] : 32'h0, h_wdata[h], h_be[h]);
        else e.rdata = mem_m.exists(key) ? mem_m[key] : 32'h0;
      end
      sbq[g].push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int g = 0; g < 2; g++) begin
      dev_rvalid[g] = pend_v[g]; dev_err[g] = pend_e[g]; dev_rdata[g] = pend_d[g];
      pend_v[g] = '0; pend_e[g] = '0; pend_d[g] = '0;
    end
    @(negedge clk);
    rst_n = rst_next;
    h_req = n_req; h_we = n_we; h_addr = n_addr; h_be = n_be; h_wdata = n_wdata;
    #1;
    for (int g = 0; g < 2; g++) check_inst(g);
  endtask

  task automatic set_host(int h, logic we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    n_we[h] = we; n_addr[h] = a; n_be[h] = be; n_wdata[h] = wd;
  endtask

  task automatic rand_host(int h);
    int r = $urandom_range(0, 9);
    logic [31:0] a;
    case (r)
      0, 1, 2, 3, 4: a = 32'h0010_0000 + 32'($urandom_range(0, 15)) * 4;
      5:             a = 32'h0002_0000 + 32'($urandom_range(0, 7)) * 4;
      6:             a = 32'h0003_0000 + 32'($urandom_range(0, 7)) * 4;
      7, 8:          a = 32'h8000_0000 + (32'($urandom_range(0, 3)) << 16) + 32'($urandom_range(0, 7)) * 4;
      default:       a = 32'h4000_0000 + 32'($urandom_range(0, 7)) * 4;
    endcase
    set_host(h, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
    n_req[h] = ($urandom_range(0, 9) < 6);
  endtask

  // Scoreboard monitor: each cycle pops the grant made one cycle earlier.
  initial begin
    exp_t e;
    int   eh;
    forever begin
      @(negedge clk); #2;
      for (int g = 0; g < 2; g++) begin
        eh = -1;
        while (sbq[g].size() > 0 && sbq[g][0].cyc < cyc - 1) begin
          void'(sbq[g].pop_front());
          chk("stale_rsp", g, 512'(0), 512'(1));
        end
        if (sbq[g].size() > 0 && sbq[g][0].cyc == cyc - 1) begin
          e = sbq[g].pop_front();
          eh = e.host;
        end
        for (int h = 0; h < NH; h++) begin
          if (h == eh)
            chk($sformatf("rsp_h%0d", h), g, 512'({rvalid_s[g][h], err_s[g][h], rdata_s[g][h]}),
                512'({1'b1, e.err, e.rdata}));
          else
            chk($sformatf("idle_h%0d", h), g, 512'({rvalid_s[g][h], err_s[g][h], rdata_s[g][h]}), 512'(0));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; rst_next = 1'b0;
    n_req = '0; n_we = '0; n_addr = '0; n_be = '0; n_wdata = '0;
    h_req = '0; h_we = '0; h_addr = '0; h_be = '0; h_wdata = '0;
    for (int g = 0; g < 2; g++) begin
      dev_rvalid[g] = '0; dev_err[g] = '0; dev_rdata[g] = '0;
      pend_v[g] = '0; pend_e[g] = '0; pend_d[g] = '0; rr_m[g] = 0;
    end
    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_F000;
    cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_F000;
    cfg_base[3] = 32'h0010_0000; cfg_mask[3] = 32'hFFFF_0000;
    for (int d = 4; d < ND; d++) begin
      cfg_base[d] = 32'h8000_0000 + (32'(d - 4) << 16);
      cfg_mask[d] = 32'hFFFF_0000;
    end
    fx_other = 0;
    #1 rst_n = 1'b0;
    #2;
    for (int g = 0; g < 2; g++) chk("reset_rsp", g, 512'({rvalid_s[g], err_s[g]}), 512'(0));
    repeat (3) step();
    rst_next = 1'b1;
    step();

    rr_log.delete();
    n_req = 3'b111;
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, 32'h0010_0000 + 32'(h) * 4, 4'hF, 32'h0);
    repeat (6) step();
    for (int i = 0; i < 6; i++) chk("rr_order", 0, 512'(rr_log[i]), 512'(i % 3));
    chk("fixed_starve", 1, 512'(fx_other), 512'(0));

    n_req = 3'b001;
    set_host(0, 1'b1, 32'h0010_0010, 4'hF, 32'hDEAD_BEEF);
    step();
    set_host(0, 1'b0, 32'h0010_0010, 4'hF, 32'h0);
    step();
    n_req = 3'b010;
    set_host(1, 1'b0, 32'h4000_0000, 4'hF, 32'h0);
    step();
    n_req = 3'b100;
    set_host(2, 1'b0, 32'h0003_0004, 4'hF, 32'h0);
    step();
    n_req = '0;
    step();

    repeat (300) begin
      for (int h = 0; h < NH; h++) rand_host(h);
      step();
    end

    n_req = 3'b001;
    set_host(0, 1'b0, 32'h0010_0004, 4'hF, 32'h0);
    step();
    #2;
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin sbq[g].delete(); rr_m[g] = 0; end
    n_req = '0;
    step();
    rr_log.delete();
    n_req = 3'b111;
    for (int h = 0; h < NH; h++) set_host(h, 1'b0, 32'h0010_0008, 4'hF, 32'h0);
    step();
    chk("post_reset_gnt", 0, 512'(rr_log[0]), 512'(0));
    n_req = '0;
    repeat (3) step();
    for (int g = 0; g < 2; g++) chk("drained", g, 512'(sbq[g].size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
